fe_tobytes_arbiter: RTL

Round-robin scheduler that shares one combinational field-element-to-bytes converter among `NREQ` requesters, such as the point-encoding and scalar-output paths. It accepts one 10-limb field element at a time and drives it into the converter through a registered `tb_h`. It captures the 32-byte canonical result and streams it out one byte per valid/ready beat, tagged with the requester index. The converter is instantiated alongside this block, outside it.

---
 rtl/fe_tobytes_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fe_tobytes_arbiter.sv
// fe_tobytes_arbiter
// ------------------
// Round-robin scheduler that shares one external combinational
// field-element-to-bytes converter among NREQ requesters. One 10-limb field
// element (10 x 32-bit signed limbs) is accepted at a time, presented to the
// converter on the registered tb_h, and the 32-byte result (tb_s) is captured
// and streamed out little-endian, one byte per valid/ready beat, tagged with
// the requester index.
//
// Optional feature macro: FE_TOBYTES_ARB_SIGN_MERGE_EN
//   When defined, adds req_sign; the accepted requester's sign bit is XORed
//   into bit 7 of byte 31 (Ed25519 point encoding: x-sign in the MSB of y).
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   req_valid[NREQ]  per-requester request
//   req_fe           NREQ x 320-bit field elements, requester i at [i*320 +: 320]
//   req_sign[NREQ]   (macro only) per-requester sign bit
//   req_ready[NREQ]  one-hot combinational grant, non-zero only while idle
//   tb_h[320]        registered operand driven to the converter
//   tb_s[256]        converter result, byte j at [j*8 +: 8]
//   out_valid/out_ready/out_byte/out_last/out_id   byte stream to downstream

module fe_tobytes_arbiter #(
   parameter int NREQ = 2,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [NREQ*320-1:0] req_fe,
`ifdef FE_TOBYTES_ARB_SIGN_MERGE_EN
   input  logic [NREQ-1:0]     req_sign,
`endif
   output logic [NREQ-1:0]     req_ready,
   output logic [319:0]        tb_h,
   input  logic [255:0]        tb_s,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [7:0]          out_byte,
   output logic                out_last,
   output logic [IDW-1:0]      out_id
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_CONV   = 2'd1;
   localparam logic [1:0] S_STREAM = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [IDW-1:0]  last_grant_q, last_grant_d;
   logic [IDW-1:0]  out_id_q, out_id_d;
   logic [319:0]    tb_h_q, tb_h_d;
   logic [255:0]    byte_buf_q, byte_buf_d;
   logic [4:0]      cnt_q, cnt_d;
   logic            sign_merge;

   logic [NREQ-1:0] gnt_onehot;
   logic [IDW-1:0]  gnt_idx;
   logic            gnt_any;

`ifdef FE_TOBYTES_ARB_SIGN_MERGE_EN
   logic            sign_q, sign_d;
`endif

   // Round-robin search: first valid requester after last_grant, wrapping.
   always_comb begin : rr_search
      int cand;
      cand       = 0;
      gnt_onehot = '0;
      gnt_idx    = '0;
      gnt_any    = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = (int'(last_grant_q) + k) % NREQ;
         if (!gnt_any && req_valid[cand]) begin
            gnt_any          = 1'b1;
            gnt_idx          = cand[IDW-1:0];
            gnt_onehot[cand] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      out_id_d     = out_id_q;
      tb_h_d       = tb_h_q;
      byte_buf_d   = byte_buf_q;
      cnt_d        = cnt_q;
`ifdef FE_TOBYTES_ARB_SIGN_MERGE_EN
      sign_d       = sign_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (gnt_any) begin
               tb_h_d       = req_fe[gnt_idx*320 +: 320];
               out_id_d     = gnt_idx;
               last_grant_d = gnt_idx;
`ifdef FE_TOBYTES_ARB_SIGN_MERGE_EN
               sign_d       = req_sign[gnt_idx];
`endif
               state_d      = S_CONV;
            end
         end
         // tb_h has been stable for this whole cycle, so tb_s has settled.
         S_CONV: begin
            byte_buf_d = tb_s;
            cnt_d      = 5'd0;
            state_d    = S_STREAM;
         end
         S_STREAM: begin
            if (out_ready) begin
               byte_buf_d = byte_buf_q >> 8;
               cnt_d      = cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Data registers are reset too: a reset mid-job must drop every trace of it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         last_grant_q <= IDW'(NREQ - 1);
         out_id_q     <= '0;
         tb_h_q       <= '0;
         byte_buf_q   <= '0;
         cnt_q        <= 5'd0;
`ifdef FE_TOBYTES_ARB_SIGN_MERGE_EN
         sign_q       <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         out_id_q     <= out_id_d;
         tb_h_q       <= tb_h_d;
         byte_buf_q   <= byte_buf_d;
         cnt_q        <= cnt_d;
`ifdef FE_TOBYTES_ARB_SIGN_MERGE_EN
         sign_q       <= sign_d;
`endif
      end
   end

   assign req_ready = (state_q == S_IDLE) ? gnt_onehot : '0;
   assign out_valid = (state_q == S_STREAM);
   assign out_last  = out_valid && (cnt_q == 5'd31);
   assign out_id    = out_id_q;
   assign tb_h      = tb_h_q;

`ifdef FE_TOBYTES_ARB_SIGN_MERGE_EN
   assign sign_merge = sign_q & out_last;
`else
   assign sign_merge = 1'b0;
`endif

   // Outside STREAM the buffer is either reset or fully shifted out, so this is 0.
   assign out_byte = byte_buf_q[7:0] ^ {sign_merge, 7'b0};

endmodule
